// File: rtl/mul_operand_loader_if.sv
// Word stream in, operand pair out: the handshake and data signals between the
// word source, the operand loader and the multiplier input.
interface mul_operand_loader_if #(
    parameter int BITS   = 381,
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] i_word;
    logic              i_word_val;
    logic              i_word_last;
    logic              o_word_rdy;
    logic [BITS-1:0]   o_dat_a;
    logic [BITS-1:0]   o_dat_b;
    logic              o_trunc;
    logic              o_val;
    logic              i_rdy;
    logic              o_err;

    modport master (
        output i_word, i_word_val, i_word_last, i_rdy,
        input  o_word_rdy, o_dat_a, o_dat_b, o_trunc, o_val, o_err
    );

    modport slave (
        input  i_word, i_word_val, i_word_last, i_rdy,
        output o_word_rdy, o_dat_a, o_dat_b, o_trunc, o_val, o_err
    );
endinterface

// File: rtl/mul_operand_loader.sv
// Assembles two BITS-wide multiplier operands from a stream of WORD_W words,
// least-significant word first, A before B, and presents them as one pair.
//
// state  | meaning
// -------+--------------------------------------------------------------
// LOAD_A | accepting A words, cnt = slice being written
// LOAD_B | accepting B words, cnt = slice being written
// HOLD   | pair valid toward the multiplier, waiting for i_rdy
module mul_operand_loader #(
    parameter int BITS   = 381,
    parameter int WORD_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mul_operand_loader_if.slave bus
);
    localparam int WORDS  = (BITS + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LAST_W = BITS - (WORDS - 1) * WORD_W;
    localparam int PAD    = WORDS * WORD_W - BITS;
    // Bits of the top word that land inside the operand; the rest are discarded.
    localparam logic [WORD_W-1:0] KEEP_MASK = {WORD_W{1'b1}} >> PAD;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept, cnt_end;
    logic             wr_a, wr_b;
    logic             err_nxt, err_q;
    logic             trunc_q, trunc_nxt;
    logic             rdy_c, val_c;
    logic [BITS-1:0]  dat_a, dat_b;

    assign accept  = bus.i_word_val && (state != HOLD);
    assign cnt_end = (cnt == CNT_W'(WORDS - 1));

    // A frame restarts the truncation flag on its first word; discarded bits
    // only exist in the top word of each operand.
    assign trunc_nxt = ((wr_a && cnt == '0) ? 1'b0 : trunc_q)
                     | (cnt_end && |(bus.i_word & ~KEEP_MASK));

    // State and word counter register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= LOAD_A;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, counter, write strobes and framing check.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        rdy_c     = 1'b1;
        val_c     = 1'b0;
        case (state)
            LOAD_A: begin
                if (accept) begin
                    if (bus.i_word_last) begin
                        err_nxt = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        wr_a = 1'b1;
                        if (cnt_end) begin
                            state_nxt = LOAD_B;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (cnt_end && bus.i_word_last) begin
                        wr_b      = 1'b1;
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end else if (cnt_end || bus.i_word_last) begin
                        // Last flag missing on the final word, or present early.
                        err_nxt   = 1'b1;
                        state_nxt = LOAD_A;
                        cnt_nxt   = '0;
                    end else begin
                        wr_b    = 1'b1;
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                rdy_c = 1'b0;
                val_c = 1'b1;
                if (bus.i_rdy) begin
                    state_nxt = LOAD_A;
                end
            end
            default: begin
                state_nxt = LOAD_A;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Operand slices, truncation flag and error pulse.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dat_a   <= '0;
            dat_b   <= '0;
            trunc_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_nxt;
            if (wr_a || wr_b) begin
                trunc_q <= trunc_nxt;
            end
            for (int w = 0; w < WORDS - 1; w++) begin
                if (cnt == CNT_W'(w)) begin
                    if (wr_a) dat_a[w*WORD_W +: WORD_W] <= bus.i_word;
                    if (wr_b) dat_b[w*WORD_W +: WORD_W] <= bus.i_word;
                end
            end
            if (cnt_end) begin
                if (wr_a) dat_a[BITS-1 -: LAST_W] <= bus.i_word[LAST_W-1:0];
                if (wr_b) dat_b[BITS-1 -: LAST_W] <= bus.i_word[LAST_W-1:0];
            end
        end
    end

    assign bus.o_word_rdy = rdy_c;
    assign bus.o_val      = val_c;
    assign bus.o_err      = err_q;
    assign bus.o_trunc    = trunc_q;
    assign bus.o_dat_a    = dat_a;
    assign bus.o_dat_b    = dat_b;
endmodule

// File: tb/tb_mul_operand_loader.sv
// Directed frames into the operand loader; a frame-level model predicts the
// outputs and every cycle is compared, with literal spot checks on top.
module tb_mul_operand_loader;
    localparam int BITS   = 381;
    localparam int WORD_W = 32;
    localparam int WORDS  = 12;
    localparam int FULL_W = WORDS * WORD_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mul_operand_loader_if #(.BITS(BITS), .WORD_W(WORD_W)) bus ();

    mul_operand_loader #(.BITS(BITS), .WORD_W(WORD_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int val_cycles = 0;
    int err_cycles = 0;
    int nrdy_cycles = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [WORD_W-1:0] m_q[$];
    bit                m_hold = 1'b0;
    bit                m_err = 1'b0;
    bit                m_trunc = 1'b0;
    logic [BITS-1:0]   m_a = '0;
    logic [BITS-1:0]   m_b = '0;

    always @(posedge clk) begin
        logic [FULL_W-1:0] fa, fb;
        m_err = 1'b0;
        if (!rst) begin
            m_q.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (bus.i_rdy) m_hold = 1'b0;
        end else if (bus.i_word_val) begin
            m_q.push_back(bus.i_word);
            if (bus.i_word_last != (m_q.size() == 2 * WORDS)) begin
                m_err = 1'b1;
                m_q.delete();
            end else if (m_q.size() == 2 * WORDS) begin
                fa = '0;
                fb = '0;
                for (int i = 0; i < WORDS; i++) begin
                    fa = fa | (FULL_W'(m_q[i]) << (i * WORD_W));
                    fb = fb | (FULL_W'(m_q[WORDS + i]) << (i * WORD_W));
                end
                m_a     = fa[BITS-1:0];
                m_b     = fb[BITS-1:0];
                m_trunc = (|(fa >> BITS)) | (|(fb >> BITS));
                m_hold  = 1'b1;
                m_q.delete();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (bus.o_val) val_cycles++;
        if (bus.o_err) err_cycles++;
        if (!bus.o_word_rdy) nrdy_cycles++;
        if (!rst) begin
            chk1("rst_rdy", bus.o_word_rdy, 1'b1);
            chk1("rst_val", bus.o_val, 1'b0);
            chk1("rst_err", bus.o_err, 1'b0);
            chk1("rst_trunc", bus.o_trunc, 1'b0);
            chkw("rst_dat_a", bus.o_dat_a, '0);
            chkw("rst_dat_b", bus.o_dat_b, '0);
        end else begin
            chk1("word_rdy", bus.o_word_rdy, !m_hold);
            chk1("val", bus.o_val, m_hold);
            chk1("err", bus.o_err, m_err);
            if (m_hold) begin
                chkw("dat_a", bus.o_dat_a, m_a);
                chkw("dat_b", bus.o_dat_b, m_b);
                chk1("trunc", bus.o_trunc, m_trunc);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [WORD_W-1:0] fw [0:2*WORDS-1];

    task automatic fill(input logic [WORD_W-1:0] base);
        for (int i = 0; i < 2 * WORDS; i++) fw[i] = base + WORD_W'(i);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        val_cycles  = 0;
        err_cycles  = 0;
        nrdy_cycles = 0;
    endtask

    task automatic send(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            bus.i_word      = fw[i];
            bus.i_word_val  = 1'b1;
            bus.i_word_last = (i == last_idx);
            step(1);
        end
        bus.i_word_val  = 1'b0;
        bus.i_word_last = 1'b0;
    endtask

    initial begin
        bus.i_word      = '0;
        bus.i_word_val  = 1'b0;
        bus.i_word_last = 1'b0;
        bus.i_rdy       = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);

        // Basic frame, consumer ready.
        clear_counts();
        fill(32'd1);
        send(24, 23);
        @(negedge clk);
        chk1("lit_val", bus.o_val, 1'b1);
        chki("lit_a_lo", int'(bus.o_dat_a[31:0]), 1);
        chki("lit_a_hi", int'(bus.o_dat_a[380:352]), 12);
        chki("lit_b_lo", int'(bus.o_dat_b[31:0]), 13);
        chk1("lit_trunc", bus.o_trunc, 1'b0);
        step(2);
        chki("val_cycles_rdy", val_cycles, 1);

        // Consumer stalls for 5 cycles.
        bus.i_rdy = 1'b0;
        clear_counts();
        send(24, 23);
        step(5);
        bus.i_rdy = 1'b1;
        step(2);
        chki("val_cycles_stall", val_cycles, 6);
        chki("nrdy_cycles_stall", nrdy_cycles, 6);

        // Nonzero bits above the operand width in the top A word.
        clear_counts();
        fill(32'h1000_0000);
        fw[11] = 32'hE000_0000;
        send(24, 23);
        @(negedge clk);
        chk1("lit_trunc_set", bus.o_trunc, 1'b1);
        chki("lit_a_hi_trunc", int'(bus.o_dat_a[380:352]), 0);
        step(2);

        // Early last on word 10, then a clean frame.
        clear_counts();
        fill(32'd100);
        send(10, 9);
        step(2);
        chki("err_early_a", err_cycles, 1);
        chki("val_early_a", val_cycles, 0);
        clear_counts();
        send(24, 23);
        @(negedge clk);
        chki("lit_a_after_err", int'(bus.o_dat_a[31:0]), 100);
        chki("lit_b_after_err", int'(bus.o_dat_b[31:0]), 112);
        step(2);
        chki("val_after_err", val_cycles, 1);

        // Early last inside B.
        clear_counts();
        fill(32'hA5A5_0000);
        send(18, 17);
        step(2);
        chki("err_early_b", err_cycles, 1);
        chki("val_early_b", val_cycles, 0);

        // Missing last on word 24.
        clear_counts();
        send(24, -1);
        step(2);
        chki("err_no_last", err_cycles, 1);
        chki("val_no_last", val_cycles, 0);

        // Reset in the middle of a frame, then a fresh frame.
        fill(32'h5555_0000);
        send(15, -1);
        rst = 1'b0;
        @(negedge clk);
        chkw("lit_rst_a", bus.o_dat_a, '0);
        chk1("lit_rst_rdy", bus.o_word_rdy, 1'b1);
        step(2);
        rst = 1'b1;
        clear_counts();
        fill(32'd200);
        send(24, 23);
        @(negedge clk);
        chki("lit_a_post_rst", int'(bus.o_dat_a[31:0]), 200);
        chki("lit_b_post_rst", int'(bus.o_dat_b[31:0]), 212);
        step(3);
        chki("val_post_rst", val_cycles, 1);
        chki("err_post_rst", err_cycles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
